// File: rtl/ace_snoop_responder.sv
// -----------------------------------------------------------------------------
// ace_snoop_responder
//
// Services ACE snoop requests for one cache, one snoop at a time. An accepted
// AC request triggers a tag lookup. The lookup result and the ACSNOOP opcode
// together give the CR response and any cache state update. When the response
// carries DataTransfer, the hit line is then streamed out on CD, LSB beat
// first. Opcodes this cache does not implement get an Error response and no
// lookup.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   ac_valid_i/ac_ready_o          AC snoop handshake
//   ac_addr_i, ac_snoop_i          snoop address and ACSNOOP opcode
//   cr_valid_o/cr_ready_i          CR handshake
//   cr_resp_o                      {WasUnique, IsShared, PassDirty, Error, DataTransfer}
//   cd_valid_o/cd_ready_i          CD handshake
//   cd_data_o, cd_last_o           CD beat data, final-beat flag
//   lk_req_o, lk_addr_o            tag lookup request, held until lk_valid_i
//   lk_valid_i, lk_hit_i,
//   lk_dirty_i, lk_unique_i,
//   lk_line_i                      lookup result and line contents
//   upd_valid_o, upd_inv_o,
//   upd_clean_o                    one-cycle state update strobe, on CR handshake
// -----------------------------------------------------------------------------
module ace_snoop_responder #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int LineWidth = 512
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ac_valid_i,
   output logic                 ac_ready_o,
   input  logic [AddrWidth-1:0] ac_addr_i,
   input  logic [3:0]           ac_snoop_i,
   output logic                 cr_valid_o,
   input  logic                 cr_ready_i,
   output logic [4:0]           cr_resp_o,
   output logic                 cd_valid_o,
   input  logic                 cd_ready_i,
   output logic [DataWidth-1:0] cd_data_o,
   output logic                 cd_last_o,
   output logic                 lk_req_o,
   output logic [AddrWidth-1:0] lk_addr_o,
   input  logic                 lk_valid_i,
   input  logic                 lk_hit_i,
   input  logic                 lk_dirty_i,
   input  logic                 lk_unique_i,
   input  logic [LineWidth-1:0] lk_line_i,
   output logic                 upd_valid_o,
   output logic                 upd_inv_o,
   output logic                 upd_clean_o
);

   localparam int Beats = LineWidth / DataWidth;
   localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

   localparam logic [3:0] SnpReadOnce           = 4'b0000;
   localparam logic [3:0] SnpReadShared         = 4'b0001;
   localparam logic [3:0] SnpReadClean          = 4'b0010;
   localparam logic [3:0] SnpReadNotSharedDirty = 4'b0011;
   localparam logic [3:0] SnpReadUnique         = 4'b0111;
   localparam logic [3:0] SnpCleanShared        = 4'b1000;
   localparam logic [3:0] SnpCleanInvalid       = 4'b1001;
   localparam logic [3:0] SnpMakeInvalid        = 4'b1101;

   localparam logic [4:0] RespError = 5'b00010;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      RESP,
      DATA
   } state_t;

   // ---------------------------------------------------------------------------
   // Snoop decode
   // ---------------------------------------------------------------------------
   function automatic logic f_supported(input logic [3:0] snoop);
      return snoop inside {SnpReadOnce, SnpReadShared, SnpReadClean,
                           SnpReadNotSharedDirty, SnpReadUnique, SnpCleanShared,
                           SnpCleanInvalid, SnpMakeInvalid};
   endfunction

   // CR response for a supported opcode; a miss always answers all-zero.
   function automatic logic [4:0] f_resp(input logic [3:0] snoop,
                                         input logic       hit,
                                         input logic       dirty,
                                         input logic       uniq);
      logic dt;
      logic shared;
      logic pass_dirty;
      // NOTE: every local gets a default before the case so that no path
      // leaves a value unassigned; in always_comb the same habit is what
      // keeps a latch from being inferred.
      dt         = 1'b0;
      shared     = 1'b0;
      pass_dirty = 1'b0;
      case (snoop)
         SnpReadOnce: begin
            dt     = 1'b1;
            shared = 1'b1;
         end
         SnpReadShared, SnpReadClean, SnpReadNotSharedDirty: begin
            dt         = 1'b1;
            shared     = 1'b1;
            pass_dirty = dirty;
         end
         SnpReadUnique: begin
            dt         = 1'b1;
            pass_dirty = dirty;
         end
         SnpCleanShared: begin
            dt         = dirty;
            shared     = 1'b1;
            pass_dirty = dirty;
         end
         SnpCleanInvalid: begin
            dt         = dirty;
            pass_dirty = dirty;
         end
         default: ;  // MakeInvalid: no data, no sharing indication
      endcase
      return hit ? {uniq, shared, pass_dirty, 1'b0, dt} : 5'b00000;
   endfunction

   // Invalidating opcodes drop our copy on a hit.
   function automatic logic f_inv(input logic [3:0] snoop, input logic hit);
      return hit && (snoop inside {SnpReadUnique, SnpCleanInvalid, SnpMakeInvalid});
   endfunction

   // Sharing/cleaning opcodes hand dirty data off, leaving our copy clean.
   function automatic logic f_clean(input logic [3:0] snoop,
                                    input logic       hit,
                                    input logic       dirty);
      return hit && dirty &&
             (snoop inside {SnpReadShared, SnpReadClean, SnpReadNotSharedDirty,
                            SnpCleanShared});
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                 r_state;
   logic                   r_ac_ready;
   logic [3:0]             r_snoop;
   logic                   r_lk_req;
   logic [AddrWidth-1:0]   r_lk_addr;
   logic [LineWidth-1:0]   r_line;
   logic                   r_cr_valid;
   logic [4:0]             r_cr_resp;
   logic                   r_inv_pend;
   logic                   r_clean_pend;
   logic                   r_cd_valid;
   logic [DataWidth-1:0]   r_cd_data;
   logic                   r_cd_last;
   logic [BeatW-1:0]       r_beat;

   logic                   w_ac_fire;
   logic                   w_upd_fire;
   logic [4:0]             w_lk_resp;
   logic [BeatW-1:0]       w_beat_nxt;
   logic [DataWidth-1:0]   w_nxt_data;

   assign w_ac_fire  = ac_valid_i & r_ac_ready;
   assign w_lk_resp  = f_resp(r_snoop, lk_hit_i, lk_dirty_i, lk_unique_i);
   assign w_beat_nxt = r_beat + BeatW'(1);
   assign w_nxt_data = r_line[int'(w_beat_nxt)*DataWidth +: DataWidth];

   // The update strobe coincides with the CR handshake, so it is decoded from
   // the registered pending flags and cr_ready_i rather than stored.
   assign w_upd_fire = r_cr_valid & cr_ready_i & (r_inv_pend | r_clean_pend);

   // NOTE: all state, including the wide line buffer, is in the async reset so
   // that an aborted snoop leaves no stale line or beat data on the outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_ac_ready   <= 1'b1;
         r_snoop      <= '0;
         r_lk_req     <= 1'b0;
         r_lk_addr    <= '0;
         r_line       <= '0;
         r_cr_valid   <= 1'b0;
         r_cr_resp    <= '0;
         r_inv_pend   <= 1'b0;
         r_clean_pend <= 1'b0;
         r_cd_valid   <= 1'b0;
         r_cd_data    <= '0;
         r_cd_last    <= 1'b0;
         r_beat       <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // samples the pre-edge values of the others regardless of order.
         case (r_state)
            IDLE: begin
               if (w_ac_fire) begin
                  r_ac_ready <= 1'b0;
                  r_snoop    <= ac_snoop_i;
                  if (f_supported(ac_snoop_i)) begin
                     r_state   <= LOOKUP;
                     r_lk_req  <= 1'b1;
                     r_lk_addr <= ac_addr_i;
                  end else begin
                     // Unknown opcode: answer Error without touching the tags.
                     r_state      <= RESP;
                     r_cr_valid   <= 1'b1;
                     r_cr_resp    <= RespError;
                     r_inv_pend   <= 1'b0;
                     r_clean_pend <= 1'b0;
                  end
               end
            end

            LOOKUP: begin
               if (lk_valid_i) begin
                  r_state      <= RESP;
                  r_lk_req     <= 1'b0;
                  r_lk_addr    <= '0;
                  r_line       <= lk_line_i;
                  r_cr_valid   <= 1'b1;
                  r_cr_resp    <= w_lk_resp;
                  r_inv_pend   <= f_inv(r_snoop, lk_hit_i);
                  r_clean_pend <= f_clean(r_snoop, lk_hit_i, lk_dirty_i);
               end
            end

            RESP: begin
               if (cr_ready_i) begin
                  r_cr_valid   <= 1'b0;
                  r_cr_resp    <= '0;
                  r_inv_pend   <= 1'b0;
                  r_clean_pend <= 1'b0;
                  if (r_cr_resp[0]) begin
                     r_state    <= DATA;
                     r_cd_valid <= 1'b1;
                     r_beat     <= '0;
                     r_cd_data  <= r_line[DataWidth-1:0];
                     r_cd_last  <= (Beats == 1);
                  end else begin
                     r_state    <= IDLE;
                     r_ac_ready <= 1'b1;
                  end
               end
            end

            DATA: begin
               if (cd_ready_i) begin
                  if (r_cd_last) begin
                     r_state    <= IDLE;
                     r_ac_ready <= 1'b1;
                     r_cd_valid <= 1'b0;
                     r_cd_data  <= '0;
                     r_cd_last  <= 1'b0;
                     r_beat     <= '0;
                  end else begin
                     // Preload the next beat so data and last stay registered.
                     r_beat    <= w_beat_nxt;
                     r_cd_data <= w_nxt_data;
                     r_cd_last <= (w_beat_nxt == LastBeat);
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign ac_ready_o  = r_ac_ready;
   assign lk_req_o    = r_lk_req;
   assign lk_addr_o   = r_lk_addr;
   assign cr_valid_o  = r_cr_valid;
   assign cr_resp_o   = r_cr_resp;
   assign cd_valid_o  = r_cd_valid;
   assign cd_data_o   = r_cd_data;
   assign cd_last_o   = r_cd_last;
   assign upd_valid_o = w_upd_fire;
   assign upd_inv_o   = w_upd_fire & r_inv_pend;
   assign upd_clean_o = w_upd_fire & r_clean_pend;

endmodule

// File: doc/ace_snoop_responder.md
ACE_SNOOP_RESPONDER -- requirements
Module: ace_snoop_responder

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, snoop address width.
REQ-002 SHALL have parameter DataWidth, default 64, CD data width.
REQ-003 SHALL have parameter LineWidth, default 512, cache line width; LineWidth multiple of DataWidth; Beats = LineWidth/DataWidth >= 1.
REQ-004 clk_i  input  1  single clock, all logic on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 ac_valid_i / ac_ready_o  in/out  1/1  AC snoop handshake.
REQ-007 ac_addr_i  input  AddrWidth  snoop address; ac_snoop_i  input  4  ACSNOOP encoding.
REQ-008 cr_valid_o / cr_ready_i  out/in  1/1  CR handshake; cr_resp_o  output  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
REQ-009 cd_valid_o / cd_ready_i  out/in  1/1  CD handshake; cd_data_o  output  DataWidth; cd_last_o  output  1.
REQ-010 lk_req_o  output  1; lk_addr_o  output  AddrWidth  cache tag lookup request.
REQ-011 lk_valid_i  input  1  lookup result valid; lk_hit_i, lk_dirty_i, lk_unique_i  input  1 each; lk_line_i  input  LineWidth.
REQ-012 upd_valid_o  output  1  one-cycle state update strobe; upd_inv_o, upd_clean_o  output  1 each.

Function
REQ-013 FSM states SHALL be IDLE, LOOKUP, RESP, DATA.
REQ-014 IDLE: ac_ready_o=1; on ac_valid_i&ac_ready_o latch addr/snoop, next LOOKUP; all other outputs 0.
REQ-015 LOOKUP: lk_req_o=1, lk_addr_o=latched addr, held until lk_valid_i (same-cycle lk_valid_i allowed); on lk_valid_i latch hit/dirty/unique/line, compute resp, next RESP.
REQ-016 RESP: cr_valid_o=1, cr_resp_o stable until cr_ready_i; on handshake: DataTransfer=1 -> DATA beat 0, else IDLE.
REQ-017 DATA: cd_valid_o=1, cd_data_o = line[beat*DataWidth +: DataWidth], beat 0 = LSBs; cd_last_o=1 only on beat Beats-1; beat counter advances only on cd_valid_o&cd_ready_i; last handshake -> IDLE.
REQ-018 Miss: cr_resp_o=5'b00000, no CD, no update, for all supported snoops.
REQ-019 Hit ReadOnce(0000): DT=1, IsShared=1, PassDirty=0, no update.
REQ-020 Hit ReadShared(0001)/ReadClean(0010)/ReadNotSharedDirty(0011): DT=1, IsShared=1, PassDirty=dirty; upd_clean_o=dirty.
REQ-021 Hit ReadUnique(0111): DT=1, PassDirty=dirty, IsShared=0; upd_inv_o=1.
REQ-022 Hit CleanShared(1000): DT=dirty, PassDirty=dirty, IsShared=1; upd_clean_o=dirty.
REQ-023 Hit CleanInvalid(1001): DT=dirty, PassDirty=dirty; upd_inv_o=1. Hit MakeInvalid(1101): DT=0; upd_inv_o=1.
REQ-024 WasUnique SHALL equal hit&lk_unique_i for every supported snoop.
REQ-025 Unsupported ACSNOOP: cr_resp_o=5'b00010 (Error), no CD, no update, no lookup (LOOKUP skipped, IDLE->RESP).
REQ-026 upd_valid_o SHALL pulse exactly one cycle on CR handshake when upd_inv_o|upd_clean_o; upd_* 0 otherwise.
REQ-027 Latency without backpressure: AC handshake cycle N -> lk_req_o cycle N+1 -> (lk_valid_i at N+1) cr_valid_o cycle N+2.
REQ-028 Exactly one snoop outstanding; ac_ready_o=0 outside IDLE; valid outputs never deassert without handshake.

Reset
REQ-029 While rst_ni=0, state=IDLE, beat counter=0, all valid/req/strobe outputs 0, cr_resp_o=0, cd_data_o=0, cd_last_o=0.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately; first cycle after release ac_ready_o=1.

Verification
REQ-031 Miss ReadShared addr 0x1000 -> lk_addr_o=0x1000, cr_resp_o=0x00, no cd_valid_o, ac_ready_o=1 cycle after CR handshake.
REQ-032 Hit dirty unique ReadUnique, Beats=8, line=ascending words 0..7 -> cr_resp_o=0x15, upd_inv_o pulse, 8 CD beats data 0..7, cd_last_o on 8th only.
REQ-033 Hit clean ReadOnce with random cr_ready_i/cd_ready_i stalls -> cr_resp_o=0x09, outputs stable during stalls, no beat lost/duplicated.
REQ-034 Hit clean shared MakeInvalid -> cr_resp_o=0x00, no CD, upd_inv_o=1; CleanShared hit clean -> 0x08, no CD, no update.
REQ-035 ACSNOOP=0100 -> lk_req_o never asserted, cr_resp_o=0x02.
REQ-036 rst_ni low during DATA beat 3 -> all outputs 0 same cycle; after release new ReadOnce completes normally.
